cs_window_filter: RTL and testbench

- Parametrised sliding-window computational system, successor to the fixed 9-sample CS block.
- Keeps the last N accepted samples and computes the integer average. Finds the approximate value: the largest window sample not above the average.
- Output is Y = (sum + N*appr) >> SHIFT.
- Adds input qualification, fill tracking, output-valid, flush and a two-stage pipeline. Sits between the sample source and downstream consumers of the filtered stream.

---
 rtl/cs_window_filter.sv | 119 +++++++++++
 tb/tb_cs_window_filter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cs_window_filter.sv
// Sliding-window filter: Y = (sum + N*appr) >> SHIFT over the last N accepted samples,
// 2-edge latency, no backpressure. Optional saturation of Y under macro CS_SATURATE_EN.
module cs_window_filter #(
    parameter int DW    = 8,
    parameter int N     = 9,
    parameter int SHIFT = 3,
    parameter int YW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] X,
    input  logic          in_valid,
    input  logic          flush,
    output logic [YW-1:0] Y,
    output logic          out_valid,
    output logic          full
);

    localparam int CW = $clog2(N + 1);
    localparam int SW = DW + CW;
    localparam int RW = SW + 1 + $clog2(N);

    logic [DW-1:0] win_q [N];
    logic [DW-1:0] win_d [N];
    logic [SW-1:0] sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          s1_vld_q, s1_vld_d;
    logic [YW-1:0] y_q, y_d;
    logic          out_valid_q, out_valid_d;

    logic [SW-1:0] avg;
    logic [DW-1:0] appr;
    logic [RW-1:0] res;
    logic [YW-1:0] y_res;

    // Stage 1: window shift, running sum and fill tracking.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            win_d[i] = win_q[i];
        end
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        full_d   = full_q;
        s1_vld_d = 1'b0;
        if (flush) begin
            for (int i = 0; i < N; i++) begin
                win_d[i] = '0;
            end
            sum_d  = '0;
            cnt_d  = '0;
            full_d = 1'b0;
        end else if (in_valid) begin
            win_d[0] = X;
            for (int i = 1; i < N; i++) begin
                win_d[i] = win_q[i-1];
            end
            // Unfilled slots hold zero, so subtracting the oldest slot is always correct.
            sum_d = sum_q + SW'(X) - SW'(win_q[N-1]);
            if (cnt_q != CW'(N)) begin
                cnt_d = cnt_q + 1'b1;
            end
            full_d   = (cnt_d == CW'(N));
            s1_vld_d = full_d;
        end
    end

    // Stage 2: average, approximate value and scaled result.
    always_comb begin
        avg  = sum_q / SW'(N);
        appr = '0;
        for (int i = 0; i < N; i++) begin
            if ((SW'(win_q[i]) <= avg) && (win_q[i] > appr)) begin
                appr = win_q[i];
            end
        end
        res = (RW'(sum_q) + RW'(N) * RW'(appr)) >> SHIFT;
`ifdef CS_SATURATE_EN
        y_res = ((res >> YW) != '0) ? {YW{1'b1}} : YW'(res);
`else
        y_res = YW'(res);
`endif
    end

    // A flush also squashes the result in flight so Y holds and no pulse follows it.
    always_comb begin
        out_valid_d = s1_vld_q & ~flush;
        y_d         = out_valid_d ? y_res : y_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                win_q[i] <= '0;
            end
            sum_q       <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            s1_vld_q    <= 1'b0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                win_q[i] <= win_d[i];
            end
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            s1_vld_q    <= s1_vld_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Y         = y_q;
    assign out_valid = out_valid_q;
    assign full      = full_q;

endmodule

// File: tb/tb_cs_window_filter.sv
// Directed bench for cs_window_filter; a second YW=9 instance shares the stimulus.
module tb_cs_window_filter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] x;
    logic       in_valid;
    logic       flush;
    logic [9:0] y;
    logic       out_valid;
    logic       full;
    logic [8:0] y9;
    logic       out_valid9;
    logic       full9;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cs_window_filter dut (
        .clk       (clk),
        .reset     (reset),
        .X         (x),
        .in_valid  (in_valid),
        .flush     (flush),
        .Y         (y),
        .out_valid (out_valid),
        .full      (full)
    );

    cs_window_filter #(.YW(9)) dut9 (
        .clk       (clk),
        .reset     (reset),
        .X         (x),
        .in_valid  (in_valid),
        .flush     (flush),
        .Y         (y9),
        .out_valid (out_valid9),
        .full      (full9)
    );

    // Drive at a falling edge, then advance to the next falling edge so the
    // outputs seen afterwards reflect the rising edge in between.
    task automatic cyc(input logic [7:0] xv, input logic v, input logic f, input logic r);
        x        = xv;
        in_valid = v;
        flush    = f;
        reset    = r;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        x = '0; in_valid = 1'b0; flush = 1'b0; reset = 1'b0;
        @(negedge clk);
        cyc(8'd0, 1'b0, 1'b0, 1'b0);
        check("reset_y", 32'(y), 32'd0);
        check("reset_ov", 32'(out_valid), 32'd0);
        check("reset_full", 32'(full), 32'd0);

        // Ramp 1..9: no result until the window fills.
        for (int i = 1; i <= 8; i++) begin
            cyc(8'(i), 1'b1, 1'b0, 1'b1);
            check("fill_ov", 32'(out_valid), 32'd0);
        end
        check("fill_full8", 32'(full), 32'd0);
        cyc(8'd9, 1'b1, 1'b0, 1'b1);
        check("fill_full9", 32'(full), 32'd1);
        check("fill_ov9", 32'(out_valid), 32'd0);

        // Tens stream; first output is the 1..9 window.
        cyc(8'd10, 1'b1, 1'b0, 1'b1);
        check("ramp_ov", 32'(out_valid), 32'd1);
        check("ramp_y", 32'(y), 32'd11);
        for (int i = 2; i <= 9; i++) begin
            cyc(8'(10 * i), 1'b1, 1'b0, 1'b1);
            check("tens_ov", 32'(out_valid), 32'd1);
        end
        cyc(8'd100, 1'b1, 1'b0, 1'b1);
        check("tens_y450", 32'(y), 32'd112);
        cyc(8'd0, 1'b1, 1'b0, 1'b1);
        check("tens_ov540", 32'(out_valid), 32'd1);
        check("tens_y540", 32'(y), 32'd135);

        // Eight zeros then 100: appr must be 0, not the nearest value.
        for (int i = 0; i < 7; i++) begin
            cyc(8'd0, 1'b1, 1'b0, 1'b1);
        end
        cyc(8'd100, 1'b1, 1'b0, 1'b1);
        cyc(8'd0, 1'b0, 1'b0, 1'b1);
        check("zeros_ov", 32'(out_valid), 32'd1);
        check("zeros_y", 32'(y), 32'd12);

        // Nine 255s with in_valid toggling.
        for (int i = 0; i < 9; i++) begin
            cyc(8'd255, 1'b1, 1'b0, 1'b1);
            check("gap_ov_acc", 32'(out_valid), 32'd0);
            cyc(8'd7, 1'b0, 1'b0, 1'b1);
            check("gap_ov_idle", 32'(out_valid), 32'd1);
        end
        check("max_y", 32'(y), 32'd573);
`ifdef CS_SATURATE_EN
        check("yw9_y", 32'(y9), 32'd511);
`else
        check("yw9_y", 32'(y9), 32'd61);
`endif
        cyc(8'd9, 1'b0, 1'b0, 1'b1);
        check("hold_ov", 32'(out_valid), 32'd0);
        check("hold_y", 32'(y), 32'd573);
        check("hold_full", 32'(full), 32'd1);

        // Flush with a coincident sample: the 200 must be discarded.
        cyc(8'd200, 1'b1, 1'b1, 1'b1);
        check("flush_full", 32'(full), 32'd0);
        check("flush_ov", 32'(out_valid), 32'd0);
        check("flush_y", 32'(y), 32'd573);
        cyc(8'd0, 1'b0, 1'b0, 1'b1);
        check("flush_ov2", 32'(out_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(8'd5, 1'b1, 1'b0, 1'b1);
            check("refill_ov", 32'(out_valid), 32'd0);
        end
        check("refill_full8", 32'(full), 32'd0);
        cyc(8'd5, 1'b1, 1'b0, 1'b1);
        check("refill_full9", 32'(full), 32'd1);
        cyc(8'd5, 1'b1, 1'b0, 1'b1);
        check("refill_ov9", 32'(out_valid), 32'd1);
        check("refill_y", 32'(y), 32'd11);

        // Reset mid-stream discards everything in flight.
        cyc(8'd5, 1'b1, 1'b0, 1'b0);
        check("mreset_y", 32'(y), 32'd0);
        check("mreset_ov", 32'(out_valid), 32'd0);
        check("mreset_full", 32'(full), 32'd0);
        cyc(8'd5, 1'b1, 1'b0, 1'b1);
        cyc(8'd5, 1'b1, 1'b0, 1'b1);
        check("post_reset_ov", 32'(out_valid), 32'd0);
        check("post_reset_full", 32'(full), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
